// File: rtl/sobel_frame_scheduler.sv
// Frame-level ap_ctrl_hs sequencer for the Sobel kernel: runs N frames or free-runs,
// counts completed frames and trips a sticky fault when the kernel stays blocked too long.
module sobel_frame_scheduler #(
  parameter int FRAME_CNT_W = 16,
  parameter int WDOG_W      = 20,
  parameter int WDOG_LIMIT  = 1000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_start,
  input  logic                   cmd_stop,
  input  logic                   err_clear,
  input  logic [FRAME_CNT_W-1:0] cfg_frames,
  output logic                   ap_start,
  input  logic                   ap_ready,
  input  logic                   ap_done,
  input  logic                   ap_idle,
  input  logic                   kernel_block,
  output logic                   busy,
  output logic                   frame_done_pulse,
  output logic [FRAME_CNT_W-1:0] frames_done,
  output logic                   deadlock_err,
  output logic [WDOG_W-1:0]      wdog_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [FRAME_CNT_W-1:0] target_q, target_d;
  logic [FRAME_CNT_W-1:0] frames_q, frames_d;
  logic [WDOG_W-1:0]      wdog_q, wdog_d;
  logic                   stop_q, stop_d;
  logic                   err_q, err_d;
  logic                   pulse_q, pulse_d;
  logic                   ap_start_q, ap_start_d;
  logic                   busy_q, busy_d;
  logic                   done_s;
  logic [WDOG_W-1:0]      wdog_inc_s;

  // ap_idle is status only; the sequencer never needs it.
  logic unused_ap_idle_s;
  assign unused_ap_idle_s = ap_idle;

  assign wdog_inc_s = wdog_q + WDOG_W'(1);

  // Next-state, frame accounting and watchdog.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    frames_d = frames_q;
    stop_d   = stop_q;
    err_d    = err_q;
    pulse_d  = 1'b0;
    wdog_d   = '0;
    done_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          target_d = cfg_frames;
          frames_d = '0;
          stop_d   = cmd_stop;
          state_d  = ST_LAUNCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH, ST_RUN: begin
        if (cmd_stop) begin
          stop_d = 1'b1;
        end else begin
          stop_d = stop_q;
        end
        // A done that arrives with ready in LAUNCH completes the frame immediately.
        done_s = ap_done && ((state_q == ST_RUN) || ap_ready);
        if (done_s) begin
          frames_d = frames_q + FRAME_CNT_W'(1);
          pulse_d  = 1'b1;
          if (stop_d || ((target_q != '0) && (frames_d == target_q))) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LAUNCH;
          end
        end else begin
          if (kernel_block) begin
            wdog_d = wdog_inc_s;
          end else begin
            wdog_d = '0;
          end
          if (kernel_block && (wdog_inc_s == WDOG_W'(WDOG_LIMIT))) begin
            state_d = ST_FAULT;
            err_d   = 1'b1;
          end else if ((state_q == ST_LAUNCH) && ap_ready) begin
            state_d = ST_RUN;
          end else begin
            state_d = state_q;
          end
        end
      end
      ST_FAULT: begin
        if (err_clear) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_d == ST_IDLE) || (state_d == ST_FAULT)) begin
      stop_d = 1'b0;
    end else begin
      stop_d = stop_d;
    end

    ap_start_d = (state_d == ST_LAUNCH);
    busy_d     = (state_d == ST_LAUNCH) || (state_d == ST_RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      target_q   <= '0;
      frames_q   <= '0;
      wdog_q     <= '0;
      stop_q     <= 1'b0;
      err_q      <= 1'b0;
      pulse_q    <= 1'b0;
      ap_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      frames_q   <= frames_d;
      wdog_q     <= wdog_d;
      stop_q     <= stop_d;
      err_q      <= err_d;
      pulse_q    <= pulse_d;
      ap_start_q <= ap_start_d;
      busy_q     <= busy_d;
    end
  end

  assign ap_start         = ap_start_q;
  assign busy             = busy_q;
  assign frame_done_pulse = pulse_q;
  assign frames_done      = frames_q;
  assign deadlock_err     = err_q;
  assign wdog_count       = wdog_q;

endmodule

// File: tb/tb_sobel_frame_scheduler.sv
// Randomised and directed bench for sobel_frame_scheduler against a behavioural model,
// with a small kernel responder driving ap_ready/ap_done.
module tb_sobel_frame_scheduler;
  localparam int FW  = 16;
  localparam int WW  = 20;
  localparam int LIM = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_start = 1'b0, cmd_stop = 1'b0, err_clear = 1'b0;
  logic [FW-1:0] cfg_frames = '0;
  logic          ap_ready = 1'b0, ap_done = 1'b0, ap_idle = 1'b1, kernel_block = 1'b0;
  logic          ap_start, busy, frame_done_pulse, deadlock_err;
  logic [FW-1:0] frames_done;
  logic [WW-1:0] wdog_count;

  always #5 clock = ~clock;

  sobel_frame_scheduler #(.FRAME_CNT_W(FW), .WDOG_W(WW), .WDOG_LIMIT(LIM)) dut (
    .clock(clock), .reset(reset), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .err_clear(err_clear), .cfg_frames(cfg_frames), .ap_start(ap_start),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .kernel_block(kernel_block), .busy(busy), .frame_done_pulse(frame_done_pulse),
    .frames_done(frames_done), .deadlock_err(deadlock_err), .wdog_count(wdog_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: a run is "active", the handshake is "offered" until accepted.
  logic          m_active, m_offer, m_fault, m_stop, m_pulse;
  logic [FW-1:0] m_frames, m_target;
  int            m_blocked;

  task automatic model_reset();
    m_active = 1'b0; m_offer = 1'b0; m_fault = 1'b0; m_stop = 1'b0; m_pulse = 1'b0;
    m_frames = '0; m_target = '0; m_blocked = 0;
  endtask

  task automatic model_step();
    logic frame_end;
    m_pulse = 1'b0;
    if (m_fault) begin
      m_blocked = 0;
      if (err_clear) m_fault = 1'b0;
    end else if (!m_active) begin
      m_blocked = 0;
      if (cmd_start) begin
        m_target = cfg_frames; m_frames = '0; m_stop = cmd_stop;
        m_active = 1'b1; m_offer = 1'b1;
      end
    end else begin
      if (cmd_stop) m_stop = 1'b1;
      frame_end = ap_done && (!m_offer || ap_ready);
      if (frame_end) begin
        m_frames = m_frames + 1'b1;
        m_pulse = 1'b1;
        m_blocked = 0;
        if (m_stop || (m_target != 0 && m_frames == m_target)) begin
          m_active = 1'b0; m_offer = 1'b0; m_stop = 1'b0;
        end else begin
          m_offer = 1'b1;
        end
      end else begin
        m_blocked = kernel_block ? m_blocked + 1 : 0;
        if (m_blocked == LIM) begin
          m_fault = 1'b1; m_active = 1'b0; m_offer = 1'b0; m_stop = 1'b0;
        end else if (m_offer && ap_ready) begin
          m_offer = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("ap_start", ap_start, m_offer);
    check("busy", busy, m_active);
    check("pulse", frame_done_pulse, m_pulse);
    check("frames_done", frames_done, m_frames);
    check("deadlock_err", deadlock_err, m_fault);
    check("wdog_count", wdog_count, m_blocked);
  endtask

  // Kernel responder: fixed delays when >= 0, otherwise random.
  int k_phase = 0, k_wait = 0, rdy_fix = -1, done_fix = -1;
  int n_starts = 0, n_hi = 0;
  logic prev_start = 1'b0;

  task automatic kernel_drive();
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    if (!busy) k_phase = 0;
    if (k_phase == 0 && ap_start) begin
      k_wait  = (rdy_fix >= 0) ? rdy_fix : int'($urandom_range(0, 3));
      k_phase = 1;
    end
    if (k_phase == 1) begin
      if (k_wait == 0) begin
        ap_ready = 1'b1;
        k_wait = (done_fix >= 0) ? done_fix : int'($urandom_range(0, 12));
        if (k_wait == 0) begin
          ap_done = 1'b1; k_phase = 0;
        end else begin
          k_phase = 2;
        end
      end else begin
        k_wait--;
      end
    end else if (k_phase == 2) begin
      k_wait--;
      if (k_wait == 0) begin
        ap_done = 1'b1; k_phase = 0;
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    cmd_start = 1'b0; cmd_stop = 1'b0; err_clear = 1'b0;
    compare_all();
    if (ap_start && !prev_start) n_starts++;
    if (ap_start) n_hi++;
    prev_start = ap_start;
    kernel_drive();
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while (m_active && n < budget) begin
      step();
      n++;
    end
    check("run_ends", busy, 1'b0);
  endtask

  task automatic wait_in_run(input int budget);
    int n = 0;
    while (!(m_active && !m_offer) && n < budget) begin
      step();
      n++;
    end
    check("reach_run", busy && !ap_start, 1'b1);
  endtask

  task automatic start_run(input logic [FW-1:0] frames, input logic with_stop);
    cfg_frames = frames; cmd_start = 1'b1; cmd_stop = with_stop;
    n_starts = 0; n_hi = 0;
    step();
  endtask

  initial begin
    int blk_left;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    compare_all();
    reset = 1'b0;
    step();

    // Three programmed frames with fixed kernel latency.
    rdy_fix = 1; done_fix = 10;
    start_run(16'd3, 1'b0);
    run_until_idle(200);
    check("t1_starts", n_starts, 3);
    check("t1_frames", frames_done, 3);

    // Continuous run stopped during frame 5.
    rdy_fix = 0; done_fix = 5;
    start_run(16'd0, 1'b0);
    begin
      int n = 0;
      while (!(m_frames == 4 && m_active && !m_offer) && n < 300) begin
        step(); n++;
      end
    end
    cmd_stop = 1'b1;
    step();
    run_until_idle(100);
    check("t2_frames", frames_done, 5);
    check("t2_starts", n_starts, 5);

    // Start and stop together, ready withheld.
    rdy_fix = 6; done_fix = 4;
    start_run(16'd9, 1'b1);
    run_until_idle(100);
    check("t3_start_hold", n_hi, 7);
    check("t3_starts", n_starts, 1);
    check("t3_frames", frames_done, 1);

    // Sustained block trips the watchdog.
    rdy_fix = 0; done_fix = 100;
    start_run(16'd1, 1'b0);
    wait_in_run(20);
    kernel_block = 1'b1;
    repeat (LIM) step();
    check("t4_err", deadlock_err, 1'b1);
    check("t4_ap_start", ap_start, 1'b0);
    check("t4_wdog", wdog_count, LIM);
    kernel_block = 1'b0;
    cmd_start = 1'b1;
    step();
    check("t4_start_ignored", busy, 1'b0);
    repeat (3) step();
    err_clear = 1'b1;
    step();
    check("t4_err_clear", deadlock_err, 1'b0);
    done_fix = 3;
    start_run(16'd1, 1'b0);
    check("t4_restart", busy, 1'b1);
    run_until_idle(50);
    check("t4_frames", frames_done, 1);

    // Block broken by a single low cycle never faults.
    done_fix = 100;
    start_run(16'd1, 1'b0);
    wait_in_run(20);
    kernel_block = 1'b1;
    repeat (LIM - 1) step();
    kernel_block = 1'b0;
    step();
    check("t5_wdog_low", wdog_count, 0);
    kernel_block = 1'b1;
    repeat (LIM - 1) step();
    kernel_block = 1'b0;
    check("t5_no_err", deadlock_err, 1'b0);
    run_until_idle(150);

    // Asynchronous reset in the middle of a run.
    rdy_fix = 0; done_fix = 4;
    start_run(16'd5, 1'b0);
    begin
      int n = 0;
      while (!(m_frames == 2 && m_active && !m_offer) && n < 100) begin
        step(); n++;
      end
    end
    check("t6_frames_pre", frames_done, 2);
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    ap_ready = 1'b0; ap_done = 1'b0; k_phase = 0; prev_start = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    step();

    // Random traffic.
    rdy_fix = -1; done_fix = -1; blk_left = 0;
    for (int i = 0; i < 3000; i++) begin
      cfg_frames = 16'($urandom_range(0, 4));
      cmd_start  = ($urandom_range(0, (m_active || m_fault) ? 49 : 7) == 0);
      cmd_stop   = ($urandom_range(0, 39) == 0);
      err_clear  = ($urandom_range(0, m_fault ? 9 : 99) == 0);
      if (blk_left > 0) begin
        kernel_block = 1'b1;
        blk_left--;
      end else begin
        kernel_block = 1'b0;
        if ($urandom_range(0, 9) == 0) blk_left = int'($urandom_range(1, 20));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
